// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, default vectors, PCSrc/RegDst encodings.
package cpu_pkg;

    // Fetch-stage sequencing states
    typedef enum logic [2:0] {
        F_IDLE = 3'd0,
        F_REQ  = 3'd1,
        F_WAIT = 3'd2,
        F_HOLD = 3'd3,
        F_DROP = 3'd4
    } fetch_state_e;

    // Default control-flow vectors (bit 31 = supervisor)
    localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

    // Next-PC source select shared with control
    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'd0,
        PCSRC_BRANCH = 2'd1,
        PCSRC_JUMP   = 2'd2,
        PCSRC_JR     = 2'd3
    } pcsrc_e;

    // Register-file destination select shared with control
    typedef enum logic [1:0] {
        REGDST_RT = 2'd0,
        REGDST_RD = 2'd1,
        REGDST_RA = 2'd2,
        REGDST_XP = 2'd3
    } regdst_e;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for the asynchronous interrupt line (used with IRQ_SYNC_EN).
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic irq_out
);

    logic meta_q;

    // Two-stage capture, cleared on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q  <= 1'b0;
            irq_out <= 1'b0;
        end else begin
            meta_q  <= irq_in;
            irq_out <= meta_q;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/gnt/rvalid sequencing, IF/ID register,
// redirect / illegal-op trap / IRQ vectoring.
// Build option: define IRQ_SYNC_EN to pass irq through a 2-flop synchroniser.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] ILLOP_VEC = ADDR_W'(DEF_ILLOP_VEC),
    parameter logic [ADDR_W-1:0] XADR_VEC  = ADDR_W'(DEF_XADR_VEC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              id_stall,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    input  logic              illop,
    input  logic              irq,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] epc
);

    localparam int unsigned       MSB  = ADDR_W - 1;
    localparam logic [ADDR_W-2:0] INC4 = (ADDR_W-1)'(4);

    // Sequential increment leaves the supervisor bit untouched
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        pc_inc = {pc[MSB], pc[MSB-1:0] + INC4};
    endfunction

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_d;
    logic [DATA_W-1:0] skid_q;
    logic              irq_s;
    logic              irq_take;
    logic              event_any;
    logic              in_flight;
    logic              resp;
    logic              flush;
    logic              load_if;
    logic              load_skid;

`ifdef IRQ_SYNC_EN
    irq_sync u_irq_sync (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq),
        .irq_out (irq_s)
    );
`else
    assign irq_s = irq;
`endif

    assign imem_req  = (state_q == F_REQ);
    assign imem_addr = pc_q;

    // Next state, next PC and IF/ID load strobes; events pre-empt the normal flow
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc;
        flush     = 1'b0;
        load_if   = 1'b0;
        load_skid = 1'b0;
        irq_take  = irq_s & ~pc_q[MSB];
        event_any = illop | irq_take | redir_valid;
        in_flight = (state_q == F_WAIT) || (state_q == F_DROP) ||
                    ((state_q == F_REQ) && imem_gnt);
        resp      = imem_rvalid && ((state_q == F_WAIT) || (state_q == F_DROP));

        if (event_any) begin
            flush = 1'b1;
            if (illop) begin
                pc_d  = ILLOP_VEC;
                epc_d = if_pc_plus4;
            end else if (irq_take) begin
                pc_d  = XADR_VEC;
                epc_d = pc_q;
            end else begin
                pc_d = redir_target;
            end
            // An accepted request still owes a response that must be swallowed
            state_d = (in_flight && !resp) ? F_DROP : F_REQ;
        end else begin
            unique case (state_q)
                F_IDLE: state_d = F_REQ;
                F_REQ:  if (imem_gnt) state_d = F_WAIT;
                F_WAIT: begin
                    if (imem_rvalid) begin
                        if (!id_stall) begin
                            load_if = 1'b1;
                            pc_d    = pc_inc(pc_q);
                            state_d = F_REQ;
                        end else begin
                            load_skid = 1'b1;
                            state_d   = F_HOLD;
                        end
                    end
                end
                F_HOLD: begin
                    if (!id_stall) begin
                        load_if = 1'b1;
                        pc_d    = pc_inc(pc_q);
                        state_d = F_REQ;
                    end
                end
                F_DROP: if (imem_rvalid) state_d = F_REQ;
                default: state_d = F_IDLE;
            endcase
        end
    end

    // State, PC, skid and trap-return registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= F_IDLE;
            pc_q    <= RESET_VEC;
            skid_q  <= '0;
            epc     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc     <= epc_d;
            if (load_skid) skid_q <= imem_rdata;
        end
    end

    // IF/ID register: load, hold under stall, or empty once decode has taken it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_pc_plus4 <= pc_inc('0);
            if_instr    <= '0;
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (load_if) begin
            if_valid    <= 1'b1;
            if_pc       <= pc_q;
            if_pc_plus4 <= pc_inc(pc_q);
            if_instr    <= (state_q == F_HOLD) ? skid_q : imem_rdata;
        end else if (!id_stall) begin
            if_valid <= 1'b0;
        end
    end

endmodule
